// File: rtl/key_event_fifo.sv
// Key event generator: turns a 5-bit key code into press/release/repeat events
// and queues them in a show-ahead FIFO with a level interrupt while non-empty.
module key_event_fifo #(
    parameter int DEPTH      = 8,
    parameter int REPEAT_DLY = 25000000,
    parameter int REPEAT_PER = 5000000,
    parameter int CNT_W      = 25
) (
    input  logic                     CLK_50M,
    input  logic                     RST,
    input  logic [4:0]               key_code,
    input  logic                     rd_en,
    input  logic                     ovf_clr,
    output logic [5:0]               rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     irq
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DLY_LIM = CNT_W'(REPEAT_DLY - 1);
    localparam logic [CNT_W-1:0] PER_LIM = CNT_W'(REPEAT_PER - 1);
    localparam logic [AW:0]      CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]      CNT_MAX = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

    state_t           state_q;
    logic [3:0]       key_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pend_q;
    logic             push_q;
    logic [5:0]       ev_q;

    logic       key_valid;
    logic [3:0] code_key;
    logic [CNT_W-1:0] lim;

    // Codes 17..31 behave exactly like "no key"; 16 wraps to key 15.
    assign key_valid = (key_code != 5'd0) && (key_code <= 5'd16);
    assign code_key  = key_code[3:0] - 4'd1;
    assign lim       = (state_q == HELD) ? DLY_LIM : PER_LIM;

    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            state_q <= IDLE;
            key_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            push_q  <= 1'b0;
            ev_q    <= '0;
        end else begin
            push_q <= 1'b0;
            if (pend_q) begin
                // Second half of a key swap: press of the new key.
                push_q <= 1'b1;
                ev_q   <= {2'b00, key_q};
                pend_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (key_valid) begin
                            push_q  <= 1'b1;
                            ev_q    <= {2'b00, code_key};
                            key_q   <= code_key;
                            cnt_q   <= '0;
                            state_q <= HELD;
                        end
                    end
                    default: begin
                        if (!key_valid) begin
                            push_q  <= 1'b1;
                            ev_q    <= {2'b01, key_q};
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else if (code_key != key_q) begin
                            push_q  <= 1'b1;
                            ev_q    <= {2'b01, key_q};
                            key_q   <= code_key;
                            pend_q  <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= HELD;
                        end else if (cnt_q == lim) begin
                            push_q  <= 1'b1;
                            ev_q    <= {2'b10, key_q};
                            cnt_q   <= '0;
                            state_q <= REPEAT;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    logic [5:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, irq_q;
    logic          do_rd, do_wr, drop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_MAX);
    assign count    = count_q;
    assign overflow = ovf_q;
    assign irq      = irq_q;
    assign rd_data  = empty ? 6'd0 : mem_q[rd_ptr_q];

    // A pop on a full FIFO frees the slot for a same-cycle push.
    assign do_rd = rd_en && !empty;
    assign do_wr = push_q && (!full || do_rd);
    assign drop  = push_q && full && !do_rd;

    always_comb begin
        count_d = count_q;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK_50M) begin
        if (do_wr) mem_q[wr_ptr_q] <= ev_q;
    end

    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            ovf_q   <= drop | (ovf_q & ~ovf_clr);
            irq_q   <= (count_d != '0);
        end
    end

endmodule

// File: tb/tb_key_event_fifo.sv
// Bench for key_event_fifo: directed scenarios plus random key/pop traffic,
// checked every cycle against an event-level queue model.
module tb_key_event_fifo;

    localparam int DEPTH = 4;
    localparam int DLY   = 10;
    localparam int PER   = 4;

    logic       CLK_50M = 1'b0;
    logic       RST = 1'b1;
    logic [4:0] key_code = 5'd0;
    logic       rd_en = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [5:0] rd_data;
    logic       empty, full, overflow, irq;
    logic [2:0] count;

    always #10 CLK_50M = ~CLK_50M;

    key_event_fifo #(
        .DEPTH(DEPTH), .REPEAT_DLY(DLY), .REPEAT_PER(PER), .CNT_W(25)
    ) dut (
        .CLK_50M(CLK_50M), .RST(RST), .key_code(key_code), .rd_en(rd_en),
        .ovf_clr(ovf_clr), .rd_data(rd_data), .empty(empty), .full(full),
        .count(count), .overflow(overflow), .irq(irq)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: events are {rpt, rel, key}; each generated event is
    // written to the FIFO one edge after the key code that caused it is seen.
    int m_fifo[$];
    int m_pipe[$];
    int m_held = -1;
    int m_next_rpt = 0;
    int m_cyc = 0;
    bit m_ovf = 1'b0;

    function automatic int san(input logic [4:0] c);
        return (c >= 5'd1 && c <= 5'd16) ? int'(c) : 0;
    endfunction

    task automatic model_step();
        int  ev, c;
        bit  have, pop, drop;
        m_cyc++;
        if (RST) begin
            m_fifo.delete();
            m_pipe.delete();
            m_held = -1;
            m_ovf  = 1'b0;
            return;
        end
        have = 1'b0;
        ev = 0;
        if (m_pipe.size() > 0) begin
            ev = m_pipe.pop_front();
            have = 1'b1;
            if (ev >= 32)      m_next_rpt = m_cyc + PER;
            else if (ev < 16)  m_next_rpt = m_cyc + DLY;
        end
        if (m_pipe.size() == 0) begin
            c = san(key_code);
            if (m_held < 0) begin
                if (c != 0) begin
                    m_held = c - 1;
                    m_pipe.push_back(m_held);
                end
            end else if (c == 0) begin
                m_pipe.push_back(16 + m_held);
                m_held = -1;
            end else if (c - 1 != m_held) begin
                m_pipe.push_back(16 + m_held);
                m_held = c - 1;
                m_pipe.push_back(m_held);
            end else if (m_cyc + 1 == m_next_rpt) begin
                m_pipe.push_back(32 + m_held);
            end
        end
        pop = rd_en && (m_fifo.size() > 0);
        if (pop) void'(m_fifo.pop_front());
        drop = 1'b0;
        if (have) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(ev);
            else drop = 1'b1;
        end
        m_ovf = drop ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
    endtask

    task automatic check_model();
        chk_eq("count", 32'(count), 32'(m_fifo.size()));
        chk_eq("empty", 32'(empty), 32'(m_fifo.size() == 0));
        chk_eq("full", 32'(full), 32'(m_fifo.size() == DEPTH));
        chk_eq("overflow", 32'(overflow), 32'(m_ovf));
        chk_eq("irq", 32'(irq), 32'(m_fifo.size() != 0));
        chk_eq("rd_data", 32'(rd_data), (m_fifo.size() > 0) ? 32'(m_fifo[0]) : 32'd0);
    endtask

    task automatic step();
        @(posedge CLK_50M);
        model_step();
        #1;
        check_model();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        RST = 1'b1; rd_en = 1'b0; ovf_clr = 1'b0;
        steps(2);
        RST = 1'b0;
    endtask

    int log_q[$];

    task automatic drain_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            rd_en = !empty;
            if (!empty) log_q.push_back(int'(rd_data));
            step();
        end
        rd_en = 1'b0;
    endtask

    task automatic chk_log(input string tag, input int exp[$]);
        chk_eq({tag, "_len"}, 32'(log_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < log_q.size(); i++)
            chk_eq($sformatf("%s_%0d", tag, i), 32'(log_q[i]), 32'(exp[i]));
    endtask

    int r;

    initial begin
        // Reset state
        do_reset();
        chk_eq("rst_count", 32'(count), 32'd0);
        chk_eq("rst_empty", 32'(empty), 32'd1);

        // 1: single press/release, irq two cycles after the change
        key_code = 5'd5;
        step();
        chk_eq("t1_irq_early", 32'(irq), 32'd0);
        step();
        chk_eq("t1_irq_rise", 32'(irq), 32'd1);
        step();
        key_code = 5'd0;
        steps(3);
        chk_eq("t1_count", 32'(count), 32'd2);
        chk_eq("t1_head0", 32'(rd_data), 32'h04);
        rd_en = 1'b1; step(); rd_en = 1'b0;
        chk_eq("t1_head1", 32'(rd_data), 32'h14);
        rd_en = 1'b1; step(); rd_en = 1'b0;
        chk_eq("t1_empty", 32'(empty), 32'd1);

        // 2: held key with auto-repeat
        do_reset();
        log_q.delete();
        key_code = 5'd1;
        drain_cycles(20);
        key_code = 5'd0;
        drain_cycles(6);
        chk_log("t2", '{'h00, 'h20, 'h20, 'h20, 'h10});

        // 3: swap without passing through 0
        do_reset();
        log_q.delete();
        key_code = 5'd3;
        drain_cycles(3);
        key_code = 5'd7;
        drain_cycles(3);
        key_code = 5'd0;
        drain_cycles(4);
        chk_log("t3", '{'h02, 'h12, 'h06, 'h16});

        // 4: overflow, clear, then drain in order
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            key_code = 5'(i); steps(2);
            key_code = 5'd0;  steps(2);
        end
        steps(2);
        chk_eq("t4_full", 32'(full), 32'd1);
        chk_eq("t4_count", 32'(count), 32'd4);
        chk_eq("t4_ovf", 32'(overflow), 32'd1);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        chk_eq("t4_ovf_clr", 32'(overflow), 32'd0);
        log_q.delete();
        drain_cycles(5);
        chk_log("t4", '{'h00, 'h10, 'h01, 'h11});
        chk_eq("t4_irq", 32'(irq), 32'd0);

        // 5: push and pop in the same cycle while full
        do_reset();
        for (int i = 1; i <= 2; i++) begin
            key_code = 5'(i); steps(2);
            key_code = 5'd0;  steps(2);
        end
        steps(2);
        chk_eq("t5_full", 32'(full), 32'd1);
        key_code = 5'd3;
        step();
        rd_en = 1'b1; step(); rd_en = 1'b0;
        chk_eq("t5_count", 32'(count), 32'd4);
        chk_eq("t5_ovf", 32'(overflow), 32'd0);
        chk_eq("t5_head", 32'(rd_data), 32'h10);
        rd_en = 1'b1; steps(3); rd_en = 1'b0;
        chk_eq("t5_tail", 32'(rd_data), 32'h02);
        key_code = 5'd0;

        // 6: reset mid-hold with entries queued
        do_reset();
        key_code = 5'd1; steps(2);
        key_code = 5'd0; steps(2);
        key_code = 5'd4; steps(3);
        chk_eq("t6_pre_count", 32'(count), 32'd3);
        RST = 1'b1; step();
        chk_eq("t6_rst_count", 32'(count), 32'd0);
        chk_eq("t6_rst_empty", 32'(empty), 32'd1);
        RST = 1'b0;
        steps(2);
        chk_eq("t6_count", 32'(count), 32'd1);
        chk_eq("t6_press", 32'(rd_data), 32'h03);

        // Random traffic including invalid codes and sporadic resets
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                r = $urandom_range(0, 9);
                if (r < 4)      key_code = 5'd0;
                else if (r < 8) key_code = 5'($urandom_range(1, 16));
                else            key_code = 5'($urandom_range(17, 31));
            end
            rd_en   = ($urandom_range(0, 2) == 0);
            ovf_clr = ($urandom_range(0, 15) == 0);
            RST     = ($urandom_range(0, 499) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/key_event_fifo.md
Name: key_event_fifo

Overview:
- Sits directly downstream of the keypad scan/debounce/encode chain in AHB_SEG_KEY and consumes its 5-bit key code.
- Turns code changes into discrete press, release and auto-repeat events.
- Buffers events in a small show-ahead FIFO for the AHB register wrapper to pop.
- Drives a level interrupt while events are pending.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- REPEAT_DLY, 25000000, cycles a key must be held before the first repeat event (500 ms at 50 MHz).
- REPEAT_PER, 5000000, cycles between subsequent repeat events (100 ms).
- CNT_W, 25, repeat counter width; must hold max(REPEAT_DLY, REPEAT_PER).

Ports:
- CLK_50M  in  1  system clock
- RST  in  1  synchronous reset, active-high
- key_code  in  5  0 = no key, 1..16 = key 0..15, 17..31 invalid (treated as 0)
- rd_en  in  1  pop request; one entry per cycle
- ovf_clr  in  1  clears the sticky overflow flag
- rd_data  out  6  head entry {rpt, rel, key[3:0]}; valid when empty=0
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky; set when an event is dropped
- irq  out  1  equals !empty

Behaviour:
- Reset values: rd_data=0, empty=1, full=0, count=0, overflow=0, irq=0; FSM=IDLE, counter=0, prev code=0.
- Reset mid-operation discards all FIFO contents and the held-key state. The first cycle after reset sees prev=0, so a key already held generates a press event.
- key_code is sampled every cycle and compared against prev, a registered copy. Events are generated from the registered comparison, so a push occurs 1 cycle after the code change.
- FSM IDLE (no key):
  - code becomes k≠0 → push {0,0,k-1}, counter=0, go to HELD.
- FSM HELD (key k held, counting to REPEAT_DLY):
  - code becomes 0 → push {0,1,k-1}, go to IDLE.
  - code becomes j≠k, j≠0 → push release of k, then press of j on the next cycle (two consecutive pushes), stay HELD with counter=0.
  - counter reaches REPEAT_DLY-1 → push {1,0,k-1}, counter=0, go to REPEAT.
- FSM REPEAT (key k held, counting to REPEAT_PER):
  - same change rules as HELD.
  - counter reaches REPEAT_PER-1 → push repeat event, counter=0.
- FIFO is show-ahead: rd_data always reflects the head entry. rd_en with empty=0 advances the head; the new head is visible the next cycle.
- rd_en while empty is ignored: no pointer change, no underflow flag.
- Push while full with no pop: the event is dropped, overflow is set, FIFO contents are unchanged.
- Push and pop in the same cycle while full: both succeed, count stays DEPTH, overflow is not set.
- Push and pop in the same cycle while empty: the push is stored and the pop is ignored; count becomes 1.
- Pointers are $clog2(DEPTH) bits and wrap naturally. full/empty derive from count; count is exact 0..DEPTH.
- overflow set and ovf_clr in the same cycle → overflow ends at 1 (set wins).
- A pending second push (the press after a swap release) that hits a full FIFO is dropped independently; overflow is set.
- irq is a registered level, deasserted the cycle after the last entry is popped.

Test Plan (REPEAT_DLY=10, REPEAT_PER=4, DEPTH=4 unless noted):
1. Reset → key_code=5 for 3 cycles → 0: expect entries 0x04, then 0x14; irq rises 2 cycles after code change; no repeat events.
2. Hold key_code=1 for 20 cycles: expect press 0x00, repeat 0x20 at ~10 cycles, further 0x20 every 4 cycles (3 repeats), release 0x10 on drop.
3. Swap key_code 3→7 without passing 0: expect consecutive entries 0x12 (release key2) then 0x06 (press key6).
4. Generate 6 events with rd_en=0: first 4 stored, full=1, count=4, overflow=1. ovf_clr → overflow=0. Then pop 4: data in order, empty=1, irq=0.
5. With FIFO full, assert rd_en in the same cycle as a new push: count stays 4, overflow stays 0, new entry appears at the tail.
6. Assert RST mid-hold with 3 entries queued: count=0, empty=1; after release of RST with the key still held, a fresh press event is pushed.
